// File: rtl/spi_master_tx_if.sv
// Parallel-word handshake and SPI pin bundle for spi_master_tx.
// The master modport is the transmitter side; the slave modport is its upstream/observer.
interface spi_master_tx_if #(
    parameter int N = 16
);
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         ss;
    logic         sck;
    logic         mosi;
    logic         txend;
    logic [2:0]   dbg_state;

    modport master (
        input  din, din_valid,
        output din_ready, ss, sck, mosi, txend, dbg_state
    );

    modport slave (
        output din, din_valid,
        input  din_ready, ss, sck, mosi, txend, dbg_state
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI Mode 0 master transmitter: one N-bit word per handshake, LSB first,
// framed by lead/lag guards and an inter-frame gap of CLKDIV cycles each.
module spi_master_tx #(
    parameter int N      = 16,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_tx_if.master  bus
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = $clog2(N + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_XFER = 3'd2,
        S_LAG  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_shift;
    logic [DW-1:0] r_div;
    logic [BW-1:0] r_bit;
    logic          r_ss;
    logic          r_sck;
    logic          r_mosi;
    logic          r_txend;

    logic          w_div_end;
    logic [N-1:0]  w_shift_next;

    assign w_div_end    = (r_div == DIV_LAST);
    assign w_shift_next = r_shift >> 1;

    // Handshake: a word transfers on any rising clk edge where din_valid and
    // din_ready are both high; din_ready depends only on state, never on din_valid.
    assign bus.din_ready = (r_state == S_IDLE);
    assign bus.ss        = r_ss;
    assign bus.sck       = r_sck;
    assign bus.mosi      = r_mosi;
    assign bus.txend     = r_txend;
    assign bus.dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_ss    <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_txend <= 1'b0;
        end else begin
            r_txend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    r_bit <= '0;
                    if (bus.din_valid) begin
                        r_shift <= bus.din;
                        r_ss    <= 1'b0;
                        r_mosi  <= bus.din[0];
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= S_XFER;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_sck) begin
                            // Falling edge: the only place mosi may advance.
                            r_sck <= 1'b0;
                            r_bit <= r_bit + 1'b1;
                            if (r_bit == BIT_LAST) begin
                                r_state <= S_LAG;
                            end else begin
                                r_shift <= w_shift_next;
                                r_mosi  <= w_shift_next[0];
                            end
                        end else begin
                            r_sck <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LAG: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_ss    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_txend <= 1'b1;
                        r_shift <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
